instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//   Fetch-side requester for the combinational instruction memory: owns the fetch PC,
//   drives the byte address, captures returned 32-bit words into a small prefetch FIFO,
//   and presents {pc, instr} to decode over a valid/ready handshake. Accepts branch/jump
//   redirects from execute and flags misaligned or out-of-range fetches.
// PARAMETERS
//   RESET_PC    64'h0  fetch PC loaded on reset
//   FIFO_DEPTH  2      prefetch entries (>=2, power of two)
//   IMEM_WORDS  256    instruction memory size in 32-bit words; word index >= this is out of range
// PORTS
//   clk             in   1   rising-edge clock
//   rst_n           in   1   synchronous active-low reset
//   imem_addr       out  64  byte address to instruction memory (= fetch_pc)
//   imem_instr      in   32  word returned combinationally for imem_addr
//   redirect_valid  in   1   load new fetch PC this cycle
//   redirect_pc     in   64  redirect target (byte address)
//   if_valid        out  1   FIFO head holds a valid entry
//   if_pc           out  64  PC of head entry
//   if_instr        out  32  instruction of head entry
//   if_ready        in   1   decode accepts head this cycle
//   fault           out  1   fetch stopped on misaligned/out-of-range PC
//   fault_pc        out  64  offending PC, valid while fault=1
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): fetch_pc=RESET_PC, FIFO count=0, entries zeroed, state=FETCH,
//     fault=0, fault_pc=0; hence if_valid=0, if_pc=0, if_instr=0, imem_addr=RESET_PC.
//     Reset mid-operation discards all FIFO contents and any pending redirect.
//   - imem_addr is driven straight from the fetch_pc register (no combinational path from inputs).
//   - States: FETCH, FAULT.
//   - pop = if_valid & if_ready. push allowed when count<FIFO_DEPTH or pop in the same cycle.
//   - FETCH, no redirect: if fetch_pc[63:2] >= IMEM_WORDS -> FAULT, fault_pc<=fetch_pc, no push.
//     Else if push allowed: write {fetch_pc, imem_instr} at tail, fetch_pc<=fetch_pc+4.
//     Else hold fetch_pc (backpressure).
//   - Redirect has top priority, in either state: FIFO flushed (count<=0); a same-cycle pop is
//     counted as accepted by decode; no push that cycle. If redirect_pc[1:0]!=0 -> FAULT,
//     fault_pc<=redirect_pc. Otherwise fetch_pc<=redirect_pc, state<=FETCH, fault<=0.
//   - Latency: push at edge N -> if_valid=1 after edge N. Redirect sampled at edge N ->
//     if_valid=0 after N; target entry appears at head after edge N+1 (2-cycle bubble).
//   - FAULT: no pushes, fetch_pc frozen; FIFO keeps draining to decode normally;
//     fault/fault_pc held until aligned redirect or reset.
//   - Entries leave in push order; no drop or duplicate under any ready pattern.
//   - PC arithmetic is mod 2^64; range check fires before wrap can occur.
// TESTING
//   1. Reset, mem[i]=32'h100+i, if_ready=1 -> after first edge if_valid=1; back-to-back
//      if_pc=0,4,8,... if_instr=100,101,102,... one per cycle.
//   2. if_ready=0 for 5 cycles from reset -> count saturates at 2, imem_addr holds 8, if_pc
//      stays 0; raise if_ready -> 0,4,8,C delivered, no loss/duplicate.
//   3. FIFO full, redirect to 64'h40 -> next cycle if_valid=0; following cycle if_pc=40,
//      if_instr=mem[16].
//   4. Redirect to 64'h42 -> fault=1, fault_pc=42, if_valid=0, imem_addr frozen; then
//      redirect to 64'h10 -> fault=0, if_pc=10 two cycles later.
//   5. Redirect to 64'h3F8, if_ready=1 -> 3F8, 3FC delivered, then fault=1, fault_pc=400.
//   6. rst_n=0 for one edge with FIFO full and fault=1 -> all outputs at reset values,
//      fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC owner feeding a prefetch FIFO of {pc, instr} to decode, with redirect and fault handling
module instr_fetch #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int          FIFO_DEPTH = 2,
   parameter int          IMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        if_valid,
   output logic [63:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        if_ready,
   output logic        fault,
   output logic [63:0] fault_pc
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic {FETCH, FAULT} state_t;
   state_t state, state_nx;
   logic [63:0] pc_q [FIFO_DEPTH];
   logic [31:0] ins_q [FIFO_DEPTH];
   logic [AW-1:0] head, tail;
   logic [AW:0] count;
   logic [63:0] fetch_pc, fetch_pc_nx, fault_pc_nx;
   logic pop, push, oor;
   assign pop = if_valid & if_ready;
   assign oor = fetch_pc[63:2] >= 62'(IMEM_WORDS);
   assign if_valid = count != '0;
   assign if_pc = pc_q[head];
   assign if_instr = ins_q[head];
   assign imem_addr = fetch_pc;
   assign fault = state == FAULT;
   always_comb begin
      state_nx = state;
      fetch_pc_nx = fetch_pc;
      fault_pc_nx = fault_pc;
      push = 1'b0;
      if (redirect_valid) begin
         if (|redirect_pc[1:0]) begin
            state_nx = FAULT;
            fault_pc_nx = redirect_pc;
         end else begin
            state_nx = FETCH;
            fetch_pc_nx = redirect_pc;
         end
      end else if (state == FETCH) begin
         if (oor) begin
            state_nx = FAULT;
            fault_pc_nx = fetch_pc;
         end else if (count < (AW+1)'(FIFO_DEPTH) || pop) begin
            push = 1'b1;
            fetch_pc_nx = fetch_pc + 64'd4;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= FETCH;
         fetch_pc <= RESET_PC;
         fault_pc <= '0;
         head <= '0;
         tail <= '0;
         count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pc_q[i] <= '0;
            ins_q[i] <= '0;
         end
      end else begin
         state <= state_nx;
         fetch_pc <= fetch_pc_nx;
         fault_pc <= fault_pc_nx;
         // a redirect flushes; any same-cycle pop is simply absorbed by the flush
         if (redirect_valid) begin
            head <= '0;
            tail <= '0;
            count <= '0;
         end else begin
            if (push) begin
               pc_q[tail] <= fetch_pc;
               ins_q[tail] <= imem_instr;
               tail <= tail + AW'(1);
            end
            if (pop) head <= head + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         end
      end
   end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random stimulus against a queue-based model of the fetch unit
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        if_valid;
   logic [63:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready;
   logic        fault;
   logic [63:0] fault_pc;
   int total = 0, passed = 0, fails = 0;
   logic [95:0] q[$];
   logic [63:0] m_pc, m_fpc;
   bit m_fault;

   instr_fetch dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_ready(if_ready),
      .fault(fault), .fault_pc(fault_pc)
   );

   always #5 clk = ~clk;
   assign imem_instr = 32'h100 + imem_addr[33:2];

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pc = 64'h0;
      m_fpc = 64'h0;
      m_fault = 0;
   endtask

   task automatic step(input bit rst, input bit rv, input logic [63:0] rpc, input bit rdy);
      @(negedge clk);
      rst_n = ~rst;
      redirect_valid = rv;
      redirect_pc = rpc;
      if_ready = rdy;
      #1;
      chk("if_valid", 96'(if_valid), 96'(q.size() > 0));
      if (q.size() > 0) begin
         chk("if_pc", 96'(if_pc), 96'(q[0][95:32]));
         chk("if_instr", 96'(if_instr), 96'(q[0][31:0]));
      end
      chk("imem_addr", 96'(imem_addr), 96'(m_pc));
      chk("fault", 96'(fault), 96'(m_fault));
      if (m_fault) chk("fault_pc", 96'(fault_pc), 96'(m_fpc));
      if (rst) model_reset();
      else if (rv) begin
         q.delete();
         if (rpc % 4 != 0) begin
            m_fault = 1;
            m_fpc = rpc;
         end else begin
            m_fault = 0;
            m_pc = rpc;
         end
      end else begin
         if (rdy && q.size() > 0) void'(q.pop_front());
         if (!m_fault) begin
            if (m_pc / 4 >= 256) begin
               m_fault = 1;
               m_fpc = m_pc;
            end else if (q.size() < 2) begin
               q.push_back({m_pc, 32'h100 + 32'(m_pc / 4)});
               m_pc = m_pc + 4;
            end
         end
      end
   endtask

   task automatic run(input int n, input bit rdy);
      for (int i = 0; i < n; i++) step(0, 0, 64'h0, rdy);
   endtask

   initial begin
      rst_n = 0;
      redirect_valid = 0;
      redirect_pc = 0;
      if_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      chk("rst_if_valid", 96'(if_valid), 96'(0));
      chk("rst_if_pc", 96'(if_pc), 96'(0));
      chk("rst_if_instr", 96'(if_instr), 96'(0));
      chk("rst_imem_addr", 96'(imem_addr), 96'(0));
      chk("rst_fault", 96'(fault), 96'(0));
      chk("rst_fault_pc", 96'(fault_pc), 96'(0));
      run(8, 1);
      step(1, 0, 64'h0, 0);
      run(5, 0);
      run(6, 1);
      run(3, 0);
      step(0, 1, 64'h40, 0);
      run(4, 1);
      step(0, 1, 64'h42, 1);
      run(3, 1);
      step(0, 1, 64'h10, 0);
      run(4, 1);
      step(0, 1, 64'h3F8, 1);
      run(5, 1);
      step(0, 1, 64'h3F8, 0);
      run(4, 0);
      step(1, 0, 64'h0, 0);
      @(posedge clk);
      #1;
      chk("rst2_if_pc", 96'(if_pc), 96'(0));
      chk("rst2_if_instr", 96'(if_instr), 96'(0));
      chk("rst2_fault_pc", 96'(fault_pc), 96'(0));
      run(3, 1);
      for (int i = 0; i < 500; i++) begin
         int r, t;
         logic [63:0] rpc;
         r = int'($urandom_range(0, 99));
         t = int'($urandom_range(0, 3));
         rpc = t == 0 ? 64'hFFFF_FFFF_FFFF_FFF0 :
               t == 1 ? 64'($urandom_range(0, 255)) * 4 + 64'($urandom_range(1, 3)) :
               64'($urandom_range(240, 256)) * 4;
         if (r < 2) step(1, 0, 64'h0, 1'($urandom_range(0, 1)));
         else if (r < 12) step(0, 1, rpc, 1'($urandom_range(0, 1)));
         else step(0, 0, 64'h0, $urandom_range(0, 2) != 0);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
